// File: rtl/bus_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_sync_pkg
// Brief    : Shared types and constants for the bus_sync_filter block.
// Revision : 1.0 - initial release
// ============================================================================
package bus_sync_pkg;

  typedef enum logic [0:0] {
    TRACK  = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int GLITCH_CNT_W      = 8;
  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MIN_STABLE_CYCLES = 2;

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : WIDTH x STAGES flop synchronizer, async active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bus_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : bus_sync_filter
// Brief    : Synchronizes an async bus, accepts values stable for STABLE_CYCLES
//            samples, delivers them via valid/ready. Optional glitch counter
//            enabled by defining BUS_SYNC_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_sync_filter
  import bus_sync_pkg::*;
#(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N-1:0]            IDATA,
  output logic [N-1:0]            ODATA,
  output logic                    OVALID,
  input  logic                    OREADY,
  output logic                    OVERRUN,
`ifdef BUS_SYNC_GLITCH_CNT_EN
  output logic [GLITCH_CNT_W-1:0] GLITCH_CNT,
`endif
  input  logic                    CLR_OVR
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
    $error("bus_sync_filter: SYNC_STAGES below minimum");
  end
  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_chk_stable
    $error("bus_sync_filter: STABLE_CYCLES below minimum");
  end

  logic [N-1:0]     w_s;
  state_t           r_state;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_odata;
  logic             r_ovalid;
  logic             r_overrun;

  sync_chain #(
    .WIDTH  (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .i_data (IDATA),
    .o_data (w_s)
  );

  logic w_revert;
  logic w_new_cand;
  logic w_accept;

  assign w_revert   = (w_s == r_acc);
  assign w_new_cand = (w_s != r_cand);
  assign w_accept   = (r_state == SETTLE) && !w_revert && !w_new_cand && (r_cnt == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= TRACK;
      r_acc   <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        TRACK: begin
          if (!w_revert) begin
            r_cand  <= w_s;
            r_cnt   <= CNT_W'(1);
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_revert) begin
            r_state <= TRACK;
          end else if (w_new_cand) begin
            r_cand <= w_s;
            r_cnt  <= CNT_W'(1);
          end else if (r_cnt == CNT_LAST) begin
            r_acc   <= r_cand;
            r_state <= TRACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

  // An accept on the same edge as a handshake replaces the consumed value, so no overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_odata   <= '0;
      r_ovalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_odata  <= r_cand;
        r_ovalid <= 1'b1;
      end else if (r_ovalid && OREADY) begin
        r_ovalid <= 1'b0;
      end

      if (w_accept && r_ovalid && !OREADY) begin
        r_overrun <= 1'b1;
      end else if (CLR_OVR) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign ODATA   = r_odata;
  assign OVALID  = r_ovalid;
  assign OVERRUN = r_overrun;

`ifdef BUS_SYNC_GLITCH_CNT_EN
  logic                    w_abandon;
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  assign w_abandon = (r_state == SETTLE) && (w_revert || w_new_cand);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_glitch_cnt <= '0;
    end else if (w_abandon) begin
      r_glitch_cnt <= sat_inc(r_glitch_cnt);
    end else if (CLR_OVR) begin
      r_glitch_cnt <= '0;
    end
  end

  assign GLITCH_CNT = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_sync_filter
// Brief    : Scoreboard bench for bus_sync_filter (defaults N=4, 2 sync, 4 stable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_sync_filter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] IDATA;
  logic [3:0] ODATA;
  logic       OVALID;
  logic       OREADY;
  logic       OVERRUN;
  logic       CLR_OVR;
`ifdef BUS_SYNC_GLITCH_CNT_EN
  logic [7:0] GLITCH_CNT;
`endif

  bus_sync_filter #(
    .N             (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IDATA      (IDATA),
    .ODATA      (ODATA),
    .OVALID     (OVALID),
    .OREADY     (OREADY),
    .OVERRUN    (OVERRUN),
`ifdef BUS_SYNC_GLITCH_CNT_EN
    .GLITCH_CNT (GLITCH_CNT),
`endif
    .CLR_OVR    (CLR_OVR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A new presentation is OVALID rising or ODATA changing while valid stays high.
  logic       prev_v = 1'b0;
  logic [3:0] prev_d = 4'h0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_v = 1'b0;
      prev_d = 4'h0;
    end else begin
      if (OVALID && (!prev_v || ODATA != prev_d)) begin
        if (q.size() == 0) begin
          check("unexpected_output", {28'h0, ODATA}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_data", {28'h0, ODATA}, {28'h0, e.data});
          check("sb_latency_edge", cyc, e.cyc);
        end
      end
      prev_v = OVALID;
      prev_d = ODATA;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge CLK);
      if (OVALID) cnt = cnt + 1;
    end
  endtask

  task automatic expect_at(input logic [3:0] d, input int edge_no);
    exp_t e;
    e.data = d;
    e.cyc  = edge_no;
    q.push_back(e);
  endtask

  int n;

  initial begin
    RST     = 1'b1;
    IDATA   = 4'h0;
    OREADY  = 1'b1;
    CLR_OVR = 1'b0;
    step(3);
    check("rst_odata", {28'h0, ODATA}, 0);
    check("rst_ovalid", {31'h0, OVALID}, 0);
    check("rst_overrun", {31'h0, OVERRUN}, 0);
    RST = 1'b0;
    step(2);

    // Clean change 0 -> 5
    IDATA = 4'h5;
    expect_at(4'h5, cyc + 6);
    count_valid(10, n);
    check("clean_valid_cycles", n, 1);
    check("clean_odata", {28'h0, ODATA}, 32'h5);
    check("clean_overrun", {31'h0, OVERRUN}, 0);

    // Glitch: 3 for two cycles, then back to accepted 5
    IDATA = 4'h3;
    step(2);
    IDATA = 4'h5;
    count_valid(12, n);
    check("glitch_valid_cycles", n, 0);
    check("glitch_odata", {28'h0, ODATA}, 32'h5);
`ifdef BUS_SYNC_GLITCH_CNT_EN
    check("glitch_cnt_1", {24'h0, GLITCH_CNT}, 1);
`endif

    // Candidate restart: 1 for two cycles, then 2 held
    IDATA = 4'h1;
    expect_at(4'h2, cyc + 8);
    step(2);
    IDATA = 4'h2;
    count_valid(10, n);
    check("restart_valid_cycles", n, 1);
    check("restart_odata", {28'h0, ODATA}, 32'h2);
`ifdef BUS_SYNC_GLITCH_CNT_EN
    check("glitch_cnt_2", {24'h0, GLITCH_CNT}, 2);
`endif

    // Overrun: consumer stalled across two accepts
    OREADY = 1'b0;
    IDATA  = 4'h6;
    expect_at(4'h6, cyc + 6);
    step(8);
    check("ovr_first_valid", {31'h0, OVALID}, 1);
    check("ovr_first_overrun", {31'h0, OVERRUN}, 0);
    IDATA = 4'h9;
    expect_at(4'h9, cyc + 6);
    step(8);
    check("ovr_odata", {28'h0, ODATA}, 32'h9);
    check("ovr_valid", {31'h0, OVALID}, 1);
    check("ovr_overrun", {31'h0, OVERRUN}, 1);
    CLR_OVR = 1'b1;
    step(1);
    CLR_OVR = 1'b0;
    check("ovr_cleared", {31'h0, OVERRUN}, 0);
    check("ovr_cleared_valid_held", {31'h0, OVALID}, 1);
`ifdef BUS_SYNC_GLITCH_CNT_EN
    check("glitch_cnt_cleared", {24'h0, GLITCH_CNT}, 0);
`endif

    // Simultaneous handshake and accept
    OREADY = 1'b1;
    step(1);
    OREADY = 1'b0;
    check("consume_valid_low", {31'h0, OVALID}, 0);
    IDATA = 4'h6;
    expect_at(4'h6, cyc + 6);
    step(8);
    IDATA = 4'h7;
    expect_at(4'h7, cyc + 6);
    step(5);
    OREADY = 1'b1;
    step(1);
    check("simul_odata", {28'h0, ODATA}, 32'h7);
    check("simul_valid", {31'h0, OVALID}, 1);
    check("simul_overrun", {31'h0, OVERRUN}, 0);
    step(1);
    check("simul_consumed", {31'h0, OVALID}, 0);
    check("simul_odata_hold", {28'h0, ODATA}, 32'h7);

    // Asynchronous reset in the middle of SETTLE
    IDATA = 4'hA;
    step(2);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("async_rst_odata", {28'h0, ODATA}, 0);
    check("async_rst_ovalid", {31'h0, OVALID}, 0);
    check("async_rst_overrun", {31'h0, OVERRUN}, 0);
    step(2);
    RST = 1'b0;
    expect_at(4'hA, cyc + 6);
    count_valid(10, n);
    check("post_rst_valid_cycles", n, 1);
    check("post_rst_odata", {28'h0, ODATA}, 32'hA);
`ifdef BUS_SYNC_GLITCH_CNT_EN
    check("post_rst_glitch_cnt", {24'h0, GLITCH_CNT}, 0);
`endif

    step(3);
    check("sb_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
